lzrw_stream_decompressor: RTL and testbench
===========================================

# lzrw_stream_decompressor

Parametrised LZRW-style decompression core that expands a stream of literal and copy items into a byte stream with full valid/ready backpressure on both sides. It generalises the fixed 4 KiB / 16-bit-item `decompressor_top` with these parameters: history depth, offset width and length-field width. It adds an output ready handshake, overlapping-copy support, block restart and malformed-item detection. It sits between the compressed-item fetch logic and the byte sink (UART/FIFO) of the decompression path.

## Interface
- `OFFSET_WIDTH`, default 12: copy offset field width; history depth `HIST_DEPTH = 2**OFFSET_WIDTH`.
- `LEN_WIDTH`, default 4: copy length code width.
- `MIN_MATCH`, default 3: copy length = code + `MIN_MATCH`.
- `IN_W` = `OFFSET_WIDTH+LEN_WIDTH` (derived, localparam): item width.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `data_in`  in  IN_W  item. Literal: `[7:0]` is the byte, upper bits are ignored. Copy: `[IN_W-1:OFFSET_WIDTH]` is the length code, `[OFFSET_WIDTH-1:0]` is the offset.
- `control_word_in`  in  1  0 = literal, 1 = copy.
- `block_start`  in  1  qualifies the accepted item; clears history fill before that item.
- `data_in_valid`  in  1  item offered.
- `data_in_ready`  out  1  item accepted when `data_in_valid && data_in_ready`.
- `decompressed_byte`  out  8  output byte.
- `out_valid`  out  1  output byte valid.
- `out_ready`  in  1  sink accepts the byte when `out_valid && out_ready`.
- `decompressor_busy`  out  1  FSM not IDLE (copy in progress).
- `error`  out  1  sticky malformed-item flag.

## Operation
- History: circular RAM, `HIST_DEPTH` x 8. `wptr` (OFFSET_WIDTH bits) wraps modulo `HIST_DEPTH`. Every byte loaded into the output register is written at `wptr`, then `wptr` increments.
- `fill`: bytes written since the last block start, saturating at `HIST_DEPTH-1`.
- Output register holds one byte. `data_in_ready = (state==IDLE) && !reset && (!out_valid || out_ready)`.
- FSM states: IDLE, COPY_RD, COPY.
  - IDLE, accepted literal: byte goes to the output register and history. Stay in IDLE.
  - IDLE, accepted copy, valid: `rptr = wptr - offset` (mod depth), `remain = code + MIN_MATCH`, go to COPY_RD.
  - A copy is invalid if `offset == 0` or `offset > fill`, where `fill` is taken after any `block_start` clear. An invalid copy sets `error`, is dropped, produces no output, and the FSM stays in IDLE.
  - COPY_RD: one-cycle RAM read latency, then go to COPY.
  - COPY: when the output register is free or draining, load the RAM read data, write it at `wptr`, increment `rptr`/`wptr`, and decrement `remain`. When `remain` reaches 0, go to IDLE.
- Overlapping copies (`offset < length`) must reproduce the run byte by byte. A read of an address written on the previous cycle must return the new data, using write-to-read forwarding in the RAM wrapper. This is required for `offset == 1`.
- Stall: while `out_valid && !out_ready`, there is no RAM write and no pointer advance. The read data is held or re-read. `decompressed_byte` is held stable.
- `error` clears only on `reset`. Processing continues after an error.
- Width rules: pointer arithmetic is modulo `2**OFFSET_WIDTH`. `remain` is `LEN_WIDTH+1` bits wide, sized for `2**LEN_WIDTH-1+MIN_MATCH`.

## Timing
- Reset values: `out_valid=0`, `decompressed_byte=0`, `decompressor_busy=0`, `error=0`, `data_in_ready=0` while `reset` is high, `wptr=0`, `fill=0`, state IDLE.
- Literal accepted at edge T: `out_valid=1` with the byte after T. Throughput is 1 literal/cycle while `out_ready=1`.
- Copy accepted at edge T: busy from T+1. The first byte is valid after T+2. Subsequent bytes arrive 1/cycle with `out_ready=1`. The last byte is valid after T+1+len. `data_in_ready` rises in that same cycle.
- Reset mid-copy: remaining bytes are discarded. Outputs take reset values after the reset edge.
- `block_start` on a literal: `fill` becomes 1 after the item.

## Test plan
- Literals 0x61, 0x62, 0x63 back-to-back, `out_ready=1` -> bytes `abc` on 3 consecutive cycles starting at accept+1; `data_in_ready` stays 1.
- `abc`, then copy code 0 offset 3 -> output `abcabc`. First copy byte at accept+2. Busy for 3 cycles.
- Literal `x`, then copy code 2 offset 1 -> output `xxxxxx` (overlap/forwarding).
- Copy len 5, `out_ready` low for 3 cycles after the 2nd byte -> byte held stable, no duplication or loss, `abcab`-style sequence intact.
- `block_start=1` copy offset 5 -> `error=1`, no `out_valid`. Also offset 0 after 10 literals -> `error=1`. A following literal still decodes.
- `OFFSET_WIDTH=4`: 20 literals 0..19, copy code 0 offset 15 -> output 5,6,7 (wrap-around). Reset asserted mid-copy -> `out_valid=0` the next cycle and `fill` cleared.

Source files
------------

// File: rtl/lzrw_stream_decompressor.sv
`default_nettype none
// ============================================================================
//  Module      : lzrw_hist_ram / lzrw_stream_decompressor
//  Description : LZRW-style stream decompressor. It expands literal and copy
//                items into a byte stream, with valid/ready on both sides.
//                History is a circular RAM of 2**OFFSET_WIDTH bytes.
//                Write-to-read forwarding lets overlapping copies, down to
//                offset 1, replay bytes produced on the previous cycle.
//  Ports (top) : clock, reset             - clock, synchronous active-high reset
//                data_in[IN_W-1:0]        - item: literal byte in [7:0], or
//                                           {len_code, offset} for a copy
//                control_word_in          - 0 literal, 1 copy
//                block_start              - clears history fill before the item
//                data_in_valid/ready      - item handshake
//                decompressed_byte[7:0]   - output byte
//                out_valid/out_ready      - output handshake
//                decompressor_busy        - a copy is in progress
//                error                    - sticky malformed-copy flag
//  Revision    : 1.0 - initial release
// ============================================================================

// History RAM with a one-cycle synchronous read. A read and a write to the
// same address in the same cycle return the data being written.
module lzrw_hist_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data
);
    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [7:0] r_mem [0:c_DEPTH-1];
    logic [7:0] r_rd_data;

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
            r_rd_data <= i_wr_data;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
endmodule

module lzrw_stream_decompressor #(
    parameter int OFFSET_WIDTH = 12,
    parameter int LEN_WIDTH    = 4,
    parameter int MIN_MATCH    = 3,
    localparam int IN_W        = OFFSET_WIDTH + LEN_WIDTH
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [IN_W-1:0] data_in,
    input  logic            control_word_in,
    input  logic            block_start,
    input  logic            data_in_valid,
    output logic            data_in_ready,
    output logic [7:0]      decompressed_byte,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            decompressor_busy,
    output logic            error
);
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_COPY_RD = 2'd1;
    localparam logic [1:0] c_ST_COPY    = 2'd2;

    localparam logic [OFFSET_WIDTH-1:0] c_FILL_MAX  = '1;
    localparam logic [LEN_WIDTH:0]      c_MIN_MATCH = (LEN_WIDTH + 1)'(MIN_MATCH);

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [OFFSET_WIDTH-1:0] r_wptr;
    logic [OFFSET_WIDTH-1:0] r_rptr;
    logic [OFFSET_WIDTH-1:0] r_fill;
    logic [LEN_WIDTH:0]      r_remain;
    logic                    r_out_valid;
    logic [7:0]              r_out_byte;
    logic                    r_error;

    logic                    w_out_free;
    logic                    w_accept;
    logic [LEN_WIDTH-1:0]    w_len_code;
    logic [OFFSET_WIDTH-1:0] w_offset;
    logic [OFFSET_WIDTH-1:0] w_fill_base;
    logic                    w_copy_bad;
    logic                    w_lit_load;
    logic                    w_copy_ok;
    logic                    w_copy_err;
    logic                    w_copy_load;
    logic                    w_load;
    logic [7:0]              w_load_byte;
    logic [OFFSET_WIDTH-1:0] w_rd_addr;
    logic [7:0]              w_ram_rd;

    // The output register can take a new byte when empty or being drained.
    assign w_out_free  = !r_out_valid || out_ready;
    assign w_accept    = data_in_valid && data_in_ready;
    assign w_len_code  = data_in[IN_W-1:OFFSET_WIDTH];
    assign w_offset    = data_in[OFFSET_WIDTH-1:0];

    // A block start empties the history before its own item is judged.
    assign w_fill_base = (w_accept && block_start) ? '0 : r_fill;
    assign w_copy_bad  = (w_offset == '0) || (w_offset > w_fill_base);

    assign w_lit_load  = w_accept && !control_word_in;
    assign w_copy_ok   = w_accept && control_word_in && !w_copy_bad;
    assign w_copy_err  = w_accept && control_word_in && w_copy_bad;
    assign w_copy_load = (r_state == c_ST_COPY) && w_out_free;
    assign w_load      = w_lit_load || w_copy_load;
    assign w_load_byte = w_copy_load ? w_ram_rd : data_in[7:0];

    // Read ahead to the next source byte as soon as the current one is used.
    // During a stall the current address is simply re-read.
    assign w_rd_addr   = w_copy_load ? (r_rptr + 1'b1) : r_rptr;

    lzrw_hist_ram #(
        .ADDR_W (OFFSET_WIDTH)
    ) u_hist (
        .clock     (clock),
        .i_wr_en   (w_load && !reset),
        .i_wr_addr (r_wptr),
        .i_wr_data (w_load_byte),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_rd)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_copy_ok) begin
                    w_state_nxt = c_ST_COPY_RD;
                end
            end
            c_ST_COPY_RD: begin
                w_state_nxt = c_ST_COPY;
            end
            c_ST_COPY: begin
                if (w_copy_load && (r_remain == (LEN_WIDTH + 1)'(1))) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fill      <= '0;
            r_remain    <= '0;
            r_out_valid <= 1'b0;
            r_out_byte  <= 8'h00;
            r_error     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_byte  <= w_load_byte;
                r_wptr      <= r_wptr + 1'b1;
                r_fill      <= (w_fill_base == c_FILL_MAX) ? c_FILL_MAX
                                                           : (w_fill_base + 1'b1);
            end else begin
                if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
                if (w_accept && block_start) begin
                    r_fill <= '0;
                end
            end

            if (w_copy_ok) begin
                r_rptr   <= r_wptr - w_offset;
                r_remain <= {1'b0, w_len_code} + c_MIN_MATCH;
            end else if (w_copy_load) begin
                r_rptr   <= r_rptr + 1'b1;
                r_remain <= r_remain - 1'b1;
            end

            if (w_copy_err) begin
                r_error <= 1'b1;
            end
        end
    end

    assign data_in_ready     = (r_state == c_ST_IDLE) && !reset && w_out_free;
    assign decompressed_byte = r_out_byte;
    assign out_valid         = r_out_valid;
    assign decompressor_busy = (r_state != c_ST_IDLE);
    assign error             = r_error;
endmodule

`default_nettype wire

// File: tb/tb_lzrw_stream_decompressor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lzrw_stream_decompressor
//  Description : Self-checking bench for lzrw_stream_decompressor with a
//                16-byte history. A byte-list reference model expands every
//                accepted item. The bench compares each consumed output byte,
//                the error flag, stall stability and handshake timing against
//                that model. Directed sequences pin the model to literal
//                expected strings.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lzrw_stream_decompressor;
    localparam int OW    = 4;
    localparam int LW    = 4;
    localparam int MM    = 3;
    localparam int IW    = OW + LW;
    localparam int DEPTH = 1 << OW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [IW-1:0] data_in = '0;
    logic          control_word_in = 1'b0;
    logic          block_start = 1'b0;
    logic          data_in_valid = 1'b0;
    logic          data_in_ready;
    logic [7:0]    decompressed_byte;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          decompressor_busy;
    logic          error;

    lzrw_stream_decompressor #(
        .OFFSET_WIDTH (OW),
        .LEN_WIDTH    (LW),
        .MIN_MATCH    (MM)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .data_in           (data_in),
        .control_word_in   (control_word_in),
        .block_start       (block_start),
        .data_in_valid     (data_in_valid),
        .data_in_ready     (data_in_ready),
        .decompressed_byte (decompressed_byte),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .decompressor_busy (decompressor_busy),
        .error             (error)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: the byte sequence produced so far, fill since block start.
    logic [7:0] m_hist[$];
    logic [7:0] m_exp[$];
    int         m_fill = 0;
    logic       m_err  = 1'b0;

    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         acc_cyc[$];
    int         cp_acc  = -1;
    int         cp_len  = 0;
    int         cp_rise = -1;

    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte  = 8'h00;
    logic       rand_rdy   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        m_hist.push_back(b);
        m_exp.push_back(b);
        if (m_hist.size() > 64) void'(m_hist.pop_front());
        if (m_fill < DEPTH - 1) m_fill++;
    endtask

    task automatic model_accept(input logic bs, input logic ctl, input logic [IW-1:0] d);
        int off;
        int len;
        if (bs) m_fill = 0;
        acc_cyc.push_back(cyc + 1);
        if (!ctl) begin
            push_byte(d[7:0]);
        end else begin
            off = int'(d[OW-1:0]);
            len = int'(d[IW-1:OW]) + MM;
            if (off == 0 || off > m_fill) begin
                m_err = 1'b1;
            end else begin
                cp_acc  = cyc + 1;
                cp_len  = len;
                cp_rise = -1;
                for (int k = 0; k < len; k++) push_byte(m_hist[m_hist.size() - off]);
            end
        end
    endtask

    // Compare process: runs mid-cycle, when inputs and outputs are both stable.
    always @(negedge clock) begin
        if (reset) begin
            chk("ready_in_reset", int'(data_in_ready), 0);
            m_exp.delete();
            m_hist.delete();
            m_fill     = 0;
            m_err      = 1'b0;
            prev_stall = 1'b0;
            cp_acc     = -1;
        end else begin
            chk("error_flag", int'(error), int'(m_err));
            chk("ready_while_busy", int'(data_in_ready && decompressor_busy), 0);
            if (prev_stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_byte", int'(decompressed_byte), int'(prev_byte));
            end
            if (m_exp.size() == 0) begin
                chk("spurious_valid", int'(out_valid), 0);
            end else if (out_valid && out_ready) begin
                chk("out_byte", int'(decompressed_byte), int'(m_exp[0]));
                void'(m_exp.pop_front());
                got_q.push_back(decompressed_byte);
                got_cyc.push_back(cyc);
            end
            if (cp_acc >= 0 && cp_rise < 0 && data_in_ready) cp_rise = cyc;
            if (data_in_valid && data_in_ready) model_accept(block_start, control_word_in, data_in);
            prev_stall = out_valid && !out_ready;
            prev_byte  = decompressed_byte;
        end
    end

    // Random sink backpressure, enabled only in the random phase.
    always @(posedge clock) begin
        if (rand_rdy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // All driver tasks start and end one time unit after a rising edge.
    task automatic send(input logic bs, input logic ctl, input int d);
        bit ok;
        ok              = 1'b0;
        data_in         = IW'(d);
        control_word_in = ctl;
        block_start     = bs;
        data_in_valid   = 1'b1;
        for (int w = 0; w < 300; w++) begin
            @(negedge clock);
            if (data_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no handshake, expected one within 300 cycles");
        end
        @(posedge clock);
        #1;
        data_in_valid = 1'b0;
        block_start   = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < 400; w++) begin
            @(negedge clock);
            #1;
            if (m_exp.size() == 0 && !decompressor_busy && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d bytes pending, expected 0", m_exp.size());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input bit check);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if (check) begin
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_byte", int'(decompressed_byte), 0);
            chk("rst_busy", int'(decompressor_busy), 0);
            chk("rst_error", int'(error), 0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic clear_got();
        got_q.delete();
        got_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic chk_got(input string name, input string s);
        chk({name, "_count"}, got_q.size(), s.len());
        for (int i = 0; i < s.len() && i < got_q.size(); i++) begin
            chk(name, int'(got_q[i]), int'(s[i]));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected end of test before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        @(posedge clock);
        #1;
        do_reset(1'b1);

        // Back-to-back literals.
        clear_got();
        send(1'b1, 1'b0, 8'h61);
        send(1'b0, 1'b0, 8'h62);
        send(1'b0, 1'b0, 8'h63);
        drain();
        chk_got("lit_abc", "abc");
        chk("lit_latency", got_cyc[0] - acc_cyc[0], 0);
        chk("lit_back2back", acc_cyc[2] - acc_cyc[0], 2);
        chk("lit_consecutive", got_cyc[2] - got_cyc[0], 2);

        // Plain copy: code 0, offset 3.
        clear_got();
        send(1'b1, 1'b0, 8'h61);
        send(1'b0, 1'b0, 8'h62);
        send(1'b0, 1'b0, 8'h63);
        send(1'b0, 1'b1, 8'h03);
        drain();
        chk_got("copy_abcabc", "abcabc");
        chk("copy_first_latency", got_cyc[3] - acc_cyc[3], 2);
        chk("copy_last_latency", got_cyc[5] - acc_cyc[3], 4);
        chk("copy_ready_rise", cp_rise - cp_acc, 1 + cp_len);

        // Overlapping copy at offset 1.
        clear_got();
        send(1'b1, 1'b0, 8'h78);
        send(1'b0, 1'b1, 8'h21);
        drain();
        chk_got("overlap_x", "xxxxxx");
        chk("overlap_rate", got_cyc[5] - got_cyc[1], 4);

        // Backpressure for 3 cycles after the 2nd copy byte.
        clear_got();
        send(1'b1, 1'b0, 8'h61);
        send(1'b0, 1'b0, 8'h62);
        send(1'b0, 1'b0, 8'h63);
        send(1'b0, 1'b1, 8'h23);
        ok = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(negedge clock);
            #1;
            if (got_q.size() >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        chk("stall_reach_2nd", int'(ok), 1);
        @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b1;
        drain();
        chk_got("stall_seq", "abcabcab");
        chk("stall_gap", got_cyc[5] - got_cyc[4], 4);

        // Malformed copies.
        do_reset(1'b0);
        clear_got();
        send(1'b1, 1'b1, 8'h05);
        drain();
        chk("err_bs_copy", int'(error), 1);
        chk("err_no_output", got_q.size(), 0);
        do_reset(1'b0);
        clear_got();
        for (int i = 0; i < 10; i++) send(1'b0, 1'b0, 8'h30 + i);
        send(1'b0, 1'b1, 8'h10);
        drain();
        chk("err_offset0", int'(error), 1);
        send(1'b0, 1'b0, 8'h7a);
        drain();
        chk_got("err_continue", "0123456789z");

        // History wrap-around with a 16-byte history.
        do_reset(1'b1);
        clear_got();
        for (int i = 0; i < 20; i++) send(1'b0, 1'b0, i);
        send(1'b0, 1'b1, 8'h0F);
        drain();
        chk("wrap_count", got_q.size(), 23);
        chk("wrap_b0", int'(got_q[20]), 5);
        chk("wrap_b1", int'(got_q[21]), 6);
        chk("wrap_b2", int'(got_q[22]), 7);

        // Reset in the middle of a long copy, then fill must be empty.
        send(1'b0, 1'b1, 8'hF1);
        ok = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(negedge clock);
            #1;
            if (got_q.size() >= 26) begin
                ok = 1'b1;
                break;
            end
        end
        chk("midcopy_started", int'(ok), 1);
        @(posedge clock);
        #1;
        do_reset(1'b1);
        send(1'b0, 1'b1, 8'h01);
        drain();
        chk("fill_cleared_err", int'(error), 1);

        // Random phase.
        do_reset(1'b0);
        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset(1'b1);
            if ($urandom_range(0, 9) < 5) begin
                send($urandom_range(0, 15) == 0, 1'b0, int'($urandom_range(0, 255)));
            end else begin
                send($urandom_range(0, 15) == 0, 1'b1, int'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clock);
                #1;
            end
        end
        rand_rdy = 1'b0;
        @(posedge clock);
        #2 out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
